gpio_arbiter: RTL and testbench

GPIO_ARBITER -- requirements
Module: gpio_arbiter

---
 rtl/gpio_arbiter.sv | 113 +++++++++++
 tb/tb_gpio_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_arbiter.sv
// gpio_arbiter: round-robin arbiter giving a core master (m0) and a debug
// master (m1) single-access turns on one GPIO register port.
// Optional feature: define GPIO_ARB_LOCK_EN to add m0_lock_i/m1_lock_i, which
// let the current winner chain back-to-back accesses without returning to IDLE.
module gpio_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,
`ifdef GPIO_ARB_LOCK_EN
    input  logic        m0_lock_i,
    input  logic        m1_lock_i,
`endif
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t      state;
    logic        win;
    logic        favour_m1;
    logic        pick;
    logic        src;
    logic        hold;
    logic        load;
    logic        src_we;
    logic [31:0] src_addr;
    logic [31:0] src_data;

`ifdef GPIO_ARB_LOCK_EN
    assign hold = win ? (m1_lock_i && m1_req_i) : (m0_lock_i && m0_req_i);
`else
    assign hold = 1'b0;
`endif

    // Choose who gets the next grant: a fresh round-robin pick in IDLE, the
    // current winner when a locked master chains from RESP.
    always_comb begin
        pick     = (m0_req_i && m1_req_i) ? favour_m1 : m1_req_i;
        src      = (state == IDLE) ? pick : win;
        load     = (state == IDLE) ? (m0_req_i || m1_req_i) : (state == RESP) && hold;
        src_we   = src ? m1_we_i   : m0_we_i;
        src_addr = src ? m1_addr_i : m0_addr_i;
        src_data = src ? m1_data_i : m0_data_i;
    end

    // FSM with registered outputs; the command is latched on entry to GRANT so
    // a master dropping req after being sampled cannot abort its access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            win         <= 1'b0;
            favour_m1   <= 1'b0;
            m0_gnt_o    <= 1'b0;
            m1_gnt_o    <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_data_o   <= '0;
            m1_data_o   <= '0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
        end else begin
            m0_gnt_o    <= 1'b0;
            m1_gnt_o    <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
            case (state)
                IDLE: if (load) state <= GRANT;
                GRANT: begin
                    state <= RESP;
                    if (win) begin
                        m1_data_o   <= data_i;
                        m1_rvalid_o <= 1'b1;
                    end else begin
                        m0_data_o   <= data_i;
                        m0_rvalid_o <= 1'b1;
                    end
                end
                RESP: begin
                    state <= hold ? GRANT : IDLE;
                    if (!hold) favour_m1 <= ~win;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                win      <= src;
                m0_gnt_o <= ~src;
                m1_gnt_o <= src;
                we_o     <= src_we;
                addr_o   <= src_addr;
                data_o   <= src_data;
            end
        end
    end
endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: directed and randomized checks of gpio_arbiter against a
// transaction-level timing model (grant one cycle after sampling, response two).
module tb_gpio_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic        force_rd = 1'b0;
    logic [31:0] force_val = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_hash(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    // GPIO register port model: read data depends on the presented address
    assign rdata = force_rd ? force_val : rd_hash(addr);

    gpio_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_data_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_data_o(m1_rdata),
`ifdef GPIO_ARB_LOCK_EN
        .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
        .we_o(we), .addr_o(addr), .data_o(wdata), .data_i(rdata)
    );

    // Reference model: cycle numbers of the next allowed sample and response
    int          cyc = 0;
    int          next_sample = 0;
    int          rv_at = -1;
    bit          last = 1'b1;
    bit          win = 1'b0;
    bit          served [2];
    logic        e_g0 = 0, e_g1 = 0, e_we = 0, e_rv0 = 0, e_rv1 = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_d0 = '0, e_d1 = '0, cap = '0;
    int          who_q[$];
    int          at_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grant(input bit w);
        win = w;
        e_g0 = !w;
        e_g1 = w;
        e_we = w ? m1_we : m0_we;
        e_addr = w ? m1_addr : m0_addr;
        e_wdata = w ? m1_wdata : m0_wdata;
        cap = force_rd ? force_val : rd_hash(e_addr);
        rv_at = cyc + 2;
        next_sample = cyc + 3;
        served[w] = 1'b1;
    endtask

    // Predict the outputs of the next cycle from the inputs about to be sampled
    task automatic model_decide();
        bit w;
        bit locked;
        e_g0 = 0; e_g1 = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rv0 = 0; e_rv1 = 0;
        if (!rst) begin
            e_d0 = '0; e_d1 = '0; last = 1'b1; next_sample = cyc + 1; rv_at = -1;
            return;
        end
        if (rv_at == cyc + 1) begin
            if (win) begin e_rv1 = 1; e_d1 = cap; end
            else begin e_rv0 = 1; e_d0 = cap; end
        end
        locked = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
        locked = (cyc == rv_at) && (win ? (m1_lock && m1_req) : (m0_lock && m0_req));
`endif
        if (locked) grant(win);
        else if (cyc >= next_sample && (m0_req || m1_req)) begin
            w = (m0_req && m1_req) ? !last : m1_req;
            last = w;
            grant(w);
        end
    endtask

    task automatic check_outputs();
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("m0_data", m0_rdata, e_d0);
        chk("m1_data", m1_rdata, e_d1);
        chk("we", we, e_we);
        chk("addr", addr, e_addr);
        chk("wdata", wdata, e_wdata);
    endtask

    task automatic tick();
        model_decide();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        if (m0_gnt) begin who_q.push_back(0); at_q.push_back(cyc); end
        if (m1_gnt) begin who_q.push_back(1); at_q.push_back(cyc); end
    endtask

    task automatic drive_random();
        if (served[0] || !m0_req) begin
            served[0] = 1'b0;
            m0_req = ($urandom_range(2) == 0);
            m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
        end
        if (served[1] || !m1_req) begin
            served[1] = 1'b0;
            m1_req = ($urandom_range(2) == 0);
            m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
        end
`ifdef GPIO_ARB_LOCK_EN
        m0_lock = ($urandom_range(3) == 0);
        m1_lock = ($urandom_range(3) == 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        do_reset();
        chk("rst_m0_data", m0_rdata, 32'h0);
        chk("rst_addr", addr, 32'h0);
        tick();

        // m0 write 0x5 to 0x0; req dropped right after the sample
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h5;
        tick();
        chk("w_gnt", m0_gnt, 1'b1);
        chk("w_we", we, 1'b1);
        chk("w_data", wdata, 32'h5);
        m0_req = 0; m0_we = 0;
        tick();
        chk("w_rvalid", m0_rvalid, 1'b1);
        chk("w_we_off", we, 1'b0);
        tick();

        // m1 read of 0x4 returning 0xA5
        force_rd = 1; force_val = 32'hA5;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4;
        tick();
        chk("r_gnt", m1_gnt, 1'b1);
        chk("r_addr", addr, 32'h4);
        m1_req = 0;
        tick();
        chk("r_rvalid", m1_rvalid, 1'b1);
        chk("r_data", m1_rdata, 32'hA5);
        chk("r_m0_quiet", {m0_gnt, m0_rvalid}, 2'b00);
        tick();
        force_rd = 0;

        // both masters requesting continuously from reset
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
        who_q.delete(); at_q.delete();
        for (int i = 0; i < 12; i++) tick();
        m0_req = 0; m1_req = 0;
        chk("rr_count", who_q.size(), 4);
        for (int i = 0; i < 4 && i < who_q.size(); i++) begin
            chk("rr_order", who_q[i], i % 2);
            if (i > 0) chk("rr_gap", at_q[i] - at_q[i-1], 3);
        end
        for (int i = 0; i < 3; i++) tick();

        // reset during GRANT aborts the access
        m0_req = 1; m0_addr = 32'h8;
        tick();
        chk("ab_gnt", m0_gnt, 1'b1);
        rst = 0; m0_req = 0;
        tick();
        chk("ab_quiet", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, we}, 5'b0);
        chk("ab_addr", addr, 32'h0);
        rst = 1;
        tick();
        chk("ab_no_rvalid", m0_rvalid, 1'b0);
        tick();

`ifdef GPIO_ARB_LOCK_EN
        // locked m0 takes three back-to-back accesses before m1 gets in
        do_reset();
        m0_lock = 1; m0_req = 1; m1_req = 1;
        who_q.delete(); at_q.delete();
        for (int i = 0; i < 14; i++) begin
            tick();
            if (who_q.size() == 3) begin m0_req = 0; m0_lock = 0; end
        end
        m1_req = 0;
        chk("lk_count", who_q.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < who_q.size(); i++) chk("lk_order", who_q[i], i / 3);
        for (int i = 1; i < 3 && i < at_q.size(); i++) chk("lk_gap", at_q[i] - at_q[i-1], 2);
        for (int i = 0; i < 3; i++) tick();
        m0_lock = 0; m1_lock = 0;
`endif

        // randomized traffic against the model
        served[0] = 0; served[1] = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst = 0; tick(); rst = 1;
            end
            drive_random();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
